mux_pipe: RTL and testbench
===========================

# mux_pipe

Parametrised, pipelined N-to-1 word selector with a valid/ready handshake on both sides. Each accepted beat carries its own select code; the chosen word leaves through a registered output stage backed by a one-entry skid buffer. Full throughput, order preserved, with optional out-of-range select detection. Sits between datapath sources (register file, ALU, memory data, shifter, immediates) and pipelined consumers, replacing the fixed 7×32 combinational muxes wherever a register stage or back-pressure is needed.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- N_IN, 7, number of input channels (2..64)
- SEL_W, $clog2(N_IN), select width (derived, not overridden)
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset; asserting it clears all state immediately
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- signal  in  SEL_W  channel select for the current beat
- data_In  in  N_IN*WIDTH  flattened channels; channel k = data_In[k*WIDTH +: WIDTH]
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts the output beat
- data_Out  out  WIDTH  selected word
- sel_Out  out  SEL_W  select code that produced data_Out
- err_Out  out  1  one-cycle pulse: an out-of-range beat was dropped
- err_count  out  8  saturating count of dropped beats

## Operation
- Accept = in_valid && in_ready. Selection is sampled in the accept cycle only; later changes to data_In do not affect a captured beat.
- Storage: output register (OUT) plus one skid register (SKID), each with a valid bit.
- in_ready = !SKID.valid (registered-state only; no combinational path from out_ready).
- Each cycle, with drain = !OUT.valid || out_ready:
  - drain && SKID.valid: OUT ← SKID; SKID empties (no accept this cycle, since in_ready=0).
  - drain && !SKID.valid: OUT ← accepted beat, or OUT.valid←0 if none.
  - !drain && accept: SKID ← accepted beat; OUT holds.
  - !drain && !accept: all hold.
- Beats leave in acceptance order; none lost or duplicated.
- Out-of-range select (signal ≥ N_IN) handling: see Configuration.
- err_count saturates at 255; it never wraps.

## Timing
- Latency: accept at edge t → out_valid at t+1 when OUT is free; +1 cycle per stalled cycle otherwise.
- Throughput: one beat per cycle while out_ready=1.
- Stall: with out_ready=0, at most two beats are held (OUT+SKID); in_ready falls the cycle after SKID fills and rises the cycle after SKID drains.
- data_Out/sel_Out stable while out_valid && !out_ready.
- Reset values: out_valid=0, in_ready=1, data_Out=0, sel_Out=0, err_Out=0, err_count=0, SKID empty. Reset mid-transfer discards all held beats; no partial beat emerges after release.
- Simultaneous out_ready and accept with SKID empty: pass-through into OUT, no bubble.

## Configuration
- MUX_SEL_CHECK_EN defined: an accepted beat with signal ≥ N_IN is consumed (counts as accepted) but not stored; err_Out pulses high the following cycle; err_count increments (saturating). Dropped beat never appears at the output.
- MUX_SEL_CHECK_EN undefined: out-of-range beat is forwarded normally with data_Out = 0 and sel_Out = signal; err_Out and err_count are tied to 0.
- When N_IN = 2**SEL_W, no out-of-range code exists; both builds behave identically.

## Structure
- Package mux_pkg: MUX_DEFAULT_WIDTH (32), MUX_DEFAULT_N_IN (7), MUX_ERR_CNT_W (8), and a beat struct typedef {sel, data}.
- Sub-module mux_skid_buf: generic OUT+SKID storage and handshake, parametrised by payload width; mux_pipe holds the select decode, range check, and error counter.

## Test plan
- Default params, out_ready=1, beats signal=0..6 with data_In channel k = 32'hA000_0000+k → data_Out A000_0000..A000_0006 on consecutive cycles, 1-cycle latency, no bubbles.
- Hold out_ready=0, offer 3 beats (sel 2,4,5) → first two accepted, in_ready=0 from cycle after second; release out_ready → outputs in order 2,4,5, in_ready returns 1.
- MUX_SEL_CHECK_EN, beat signal=7 between sel 1 and sel 3 → outputs only 1 then 3; err_Out one pulse; err_count=1.
- Without macro, signal=7 → data_Out=0, sel_Out=7, err_count stays 0.
- MUX_SEL_CHECK_EN, 300 out-of-range beats → err_count=255, holds.
- Assert reset with OUT and SKID full → out_valid=0, in_ready=1 immediately; after release, first new beat emerges alone, no stale data.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the pipelined word selector.
package mux_pkg;

  localparam int unsigned MUX_DEFAULT_WIDTH = 32;
  localparam int unsigned MUX_DEFAULT_N_IN  = 7;
  localparam int unsigned MUX_DEFAULT_SEL_W = $clog2(MUX_DEFAULT_N_IN);
  localparam int unsigned MUX_ERR_CNT_W     = 8;

  typedef struct packed {
    logic [MUX_DEFAULT_SEL_W-1:0] sel;
    logic [MUX_DEFAULT_WIDTH-1:0] data;
  } mux_beat_t;

  function automatic logic [MUX_ERR_CNT_W-1:0] sat_inc(input logic [MUX_ERR_CNT_W-1:0] v);
    return (&v) ? v : v + MUX_ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Generic output register plus one-entry skid buffer with valid/ready on both sides.
// in_ready depends only on registered state, never on out_ready.
module mux_skid_buf #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          out_v_q, out_v_d;
  logic          skid_v_q, skid_v_d;
  logic [PW-1:0] out_q, out_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          drain;
  logic          accept;

  always_comb begin
    in_ready = !skid_v_q;
    accept   = in_valid && in_ready;
    drain    = !out_v_q || out_ready;
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (drain) begin
      if (skid_v_q) begin
        // Parked beat goes first to keep acceptance order.
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end else begin
        out_v_d = accept;
        if (accept) out_d = in_data;
      end
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d   = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v_q  <= 1'b0;
      out_q    <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      out_q    <= out_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_data  = out_q;

endmodule

// File: rtl/mux_pipe.sv
// Pipelined N-to-1 word selector with valid/ready handshake and skid-buffered output.
// Optional out-of-range select dropping and error counting: define MUX_SEL_CHECK_EN.
module mux_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH,
  parameter int unsigned N_IN  = MUX_DEFAULT_N_IN,
  parameter int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         signal,
  input  logic [N_IN*WIDTH-1:0]    data_In,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_Out,
  output logic [SEL_W-1:0]         sel_Out,
  output logic                     err_Out,
  output logic [MUX_ERR_CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic [WIDTH-1:0] sel_word;
  logic             drop;
  logic             buf_in_valid;
  beat_t            in_beat;
  beat_t            out_beat;

  // Codes without a matching channel yield zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      if (signal == SEL_W'(k)) sel_word = data_In[k*WIDTH +: WIDTH];
    end
  end

  assign in_beat.sel  = signal;
  assign in_beat.data = sel_word;

`ifdef MUX_SEL_CHECK_EN
  logic                     in_range;
  logic                     err_q;
  logic [MUX_ERR_CNT_W-1:0] cnt_q;

  assign in_range = 32'(signal) < N_IN;
  assign drop     = !in_range;

  // A dropped beat is still handshaken so the source is not blocked by it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= in_valid && in_ready && drop;
      if (in_valid && in_ready && drop) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign err_Out   = err_q;
  assign err_count = cnt_q;
`else
  assign drop      = 1'b0;
  assign err_Out   = 1'b0;
  assign err_count = '0;
`endif

  assign buf_in_valid = in_valid && !drop;

  mux_skid_buf #(
    .PW($bits(beat_t))
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (buf_in_valid),
    .in_ready (in_ready),
    .in_data  (in_beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_beat)
  );

  assign data_Out = out_beat.data;
  assign sel_Out  = out_beat.sel;

endmodule

// File: tb/tb_mux_pipe.sv
// Directed, table-driven bench for mux_pipe at default parameters.
module tb_mux_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N_IN  = 7;
  localparam int unsigned SEL_W = 3;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      signal;
  logic [N_IN*WIDTH-1:0] data_In;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      data_Out;
  logic [SEL_W-1:0]      sel_Out;
  logic                  err_Out;
  logic [7:0]            err_count;

  int nvec;
  int nmis;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  mux_pipe u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .signal   (signal),
    .data_In  (data_In),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_Out (data_Out),
    .sel_Out  (sel_Out),
    .err_Out  (err_Out),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int k = 0; k < int'(N_IN); k++) data_In[k*WIDTH +: WIDTH] = base + k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    for (int i = 0; i < 7; i++) begin
      vecs[i].sel      = 3'(i);
      vecs[i].exp_data = 32'hA000_0000 + i;
    end

    reset     = 1'b0;
    in_valid  = 1'b0;
    signal    = '0;
    out_ready = 1'b1;
    set_data(32'hA000_0000);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_data", data_Out, 32'd0);
    check("rst_sel", 32'(sel_Out), 32'd0);
    check("rst_err", 32'(err_Out), 32'd0);
    check("rst_cnt", 32'(err_count), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Streaming, one beat per cycle, one-cycle latency.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      signal   = vecs[i].sel;
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", data_Out, vecs[i].exp_data);
      check("stream_sel", 32'(sel_Out), 32'(vecs[i].sel));
      check("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_idle", 32'(out_valid), 32'd0);

    // Stall: two beats held, third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    signal    = 3'd2;
    tick();
    check("stall_v1", 32'(out_valid), 32'd1);
    check("stall_d1", data_Out, 32'hA000_0002);
    check("stall_r1", 32'(in_ready), 32'd1);
    signal = 3'd4;
    tick();
    check("stall_r2", 32'(in_ready), 32'd0);
    check("stall_d2", data_Out, 32'hA000_0002);
    signal = 3'd5;
    set_data(32'hDEAD_0000);
    tick();
    check("stall_r3", 32'(in_ready), 32'd0);
    check("stall_hold_d", data_Out, 32'hA000_0002);
    check("stall_hold_s", 32'(sel_Out), 32'd2);
    set_data(32'hA000_0000);
    out_ready = 1'b1;
    tick();
    check("drain_d4", data_Out, 32'hA000_0004);
    check("drain_s4", 32'(sel_Out), 32'd4);
    check("drain_r", 32'(in_ready), 32'd1);
    tick();
    check("drain_d5", data_Out, 32'hA000_0005);
    check("drain_s5", 32'(sel_Out), 32'd5);
    in_valid = 1'b0;
    tick();
    check("drain_idle", 32'(out_valid), 32'd0);

    // Out-of-range select.
`ifdef MUX_SEL_CHECK_EN
    in_valid = 1'b1;
    signal   = 3'd1;
    tick();
    check("oor_s1", 32'(sel_Out), 32'd1);
    signal = 3'd7;
    tick();
    check("oor_gap", 32'(out_valid), 32'd0);
    check("oor_err", 32'(err_Out), 32'd1);
    signal = 3'd3;
    tick();
    check("oor_s3", 32'(sel_Out), 32'd3);
    check("oor_d3", data_Out, 32'hA000_0003);
    check("oor_err_end", 32'(err_Out), 32'd0);
    check("oor_cnt", 32'(err_count), 32'd1);
    signal = 3'd7;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    check("sat_cnt", 32'(err_count), 32'd255);
    tick();
    check("sat_hold", 32'(err_count), 32'd255);
`else
    in_valid = 1'b1;
    signal   = 3'd7;
    tick();
    check("oor_valid", 32'(out_valid), 32'd1);
    check("oor_data", data_Out, 32'd0);
    check("oor_sel", 32'(sel_Out), 32'd7);
    check("oor_err", 32'(err_Out), 32'd0);
    check("oor_cnt", 32'(err_count), 32'd0);
    signal = 3'd1;
    tick();
    check("oor_next", data_Out, 32'hA000_0001);
    signal = 3'd7;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    check("oor_cnt_300", 32'(err_count), 32'd0);
`endif

    // Reset with OUT and SKID both full.
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    signal    = 3'd1;
    tick();
    signal = 3'd6;
    tick();
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_data", data_Out, 32'd0);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    check("post_rst_v0", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_v1", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    signal   = 3'd3;
    tick();
    check("post_rst_val", 32'(out_valid), 32'd1);
    check("post_rst_d", data_Out, 32'hA000_0003);
    check("post_rst_s", 32'(sel_Out), 32'd3);
    in_valid = 1'b0;
    tick();
    check("post_rst_alone", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
